// File: rtl/riscv_pkg.sv
// Shared defaults for the fetch front end: datapath width, reset PC, bubble instruction, buffer depth.
package riscv_pkg;

    localparam int          XLEN_DEFAULT      = 32;
    localparam int          DEPTH_DEFAULT     = 4;
    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

endpackage

// File: rtl/fetch_prefetch_buf.sv
// Circular prefetch buffer: entries reserved at request, filled by in-order responses, popped in order.
// Issue/fill/read pointers carry an extra wrap bit so DEPTH+1 occupancy states are distinguishable.
module fetch_prefetch_buf
    import riscv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clear,
    input  logic                     i_reserve,
    input  logic [XLEN-1:0]          i_reserve_pc,
    input  logic                     i_fill,
    input  logic [XLEN-1:0]          i_fill_instr,
    input  logic                     i_pop,
    output logic                     o_full,
    output logic                     o_head_vld,
    output logic                     o_head_filled,
    output logic [XLEN-1:0]          o_head_pc,
    output logic [XLEN-1:0]          o_head_instr,
    output logic [$clog2(DEPTH):0]   o_unfilled_cnt,
    output logic                     o_has_unfilled
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]        r_issue;
    logic [AW:0]        r_fill;
    logic [AW:0]        r_read;
    logic [XLEN-1:0]    r_pc    [DEPTH];
    logic [XLEN-1:0]    r_instr [DEPTH];
    logic [DEPTH-1:0]   r_filled;

    logic [AW:0]        w_occ;
    logic [AW-1:0]      w_issue_idx;
    logic [AW-1:0]      w_fill_idx;
    logic [AW-1:0]      w_read_idx;

    assign w_issue_idx    = r_issue[AW-1:0];
    assign w_fill_idx     = r_fill[AW-1:0];
    assign w_read_idx     = r_read[AW-1:0];
    assign w_occ          = r_issue - r_read;

    assign o_full         = (w_occ == (AW+1)'(DEPTH));
    assign o_head_vld     = (w_occ != '0);
    assign o_head_filled  = o_head_vld && r_filled[w_read_idx];
    assign o_head_pc      = r_pc[w_read_idx];
    assign o_head_instr   = r_instr[w_read_idx];
    assign o_unfilled_cnt = r_issue - r_fill;
    assign o_has_unfilled = (r_issue != r_fill);

    // Reserve and fill never target the same slot: that would need issue-fill == DEPTH, i.e. full.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_issue  <= '0;
            r_fill   <= '0;
            r_read   <= '0;
            r_filled <= '0;
        end else begin
            if (i_reserve) begin
                r_filled[w_issue_idx] <= 1'b0;
                r_issue               <= r_issue + 1'b1;
            end
            if (i_fill) begin
                r_filled[w_fill_idx] <= 1'b1;
                r_fill               <= r_fill + 1'b1;
            end
            if (i_pop) begin
                r_read <= r_read + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_reserve) begin
            r_pc[w_issue_idx] <= i_reserve_pc;
        end
        if (i_fill) begin
            r_instr[w_fill_idx] <= i_fill_instr;
        end
    end

endmodule

// File: rtl/fetch_stage_prefetch.sv
// IF stage: PC register, in-order imem request/response, prefetch buffer and IF/ID register.
// Decode stall holds IF/ID while the buffer keeps filling; redirects discard in-flight responses.
module fetch_stage_prefetch
    import riscv_pkg::*;
#(
    parameter int              XLEN      = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int              DEPTH     = DEPTH_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic            StallD,
    input  logic            FlushD,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_instr,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = AW + 1;

    logic [XLEN-1:0] r_pcf;
    logic [DW-1:0]   r_drop;
    logic [XLEN-1:0] r_instr_d;
    logic [XLEN-1:0] r_pc_d;
    logic [XLEN-1:0] r_pc4_d;
    logic            r_valid_d;

    logic            w_full;
    logic            w_head_vld;
    logic            w_head_filled;
    logic [XLEN-1:0] w_head_pc;
    logic [XLEN-1:0] w_head_instr;
    logic [AW:0]     w_unfilled;
    logic            w_has_unfilled;

    logic            w_req_vld;
    logic            w_req_fire;
    logic            w_drop_zero;
    logic            w_rsp_match;
    logic            w_rsp_take;
    logic            w_rsp_drop;
    logic            w_bypass;
    logic            w_adv;
    logic            w_pop;
    logic [DW-1:0]   w_drop_redirect;

    assign w_req_vld   = !rst && !w_full && !PCSrcE;
    assign w_req_fire  = w_req_vld && imem_req_ready;

    assign w_drop_zero = (r_drop == '0);
    assign w_rsp_match = imem_rsp_valid && w_drop_zero && w_has_unfilled;
    assign w_rsp_take  = w_rsp_match && !PCSrcE;
    assign w_rsp_drop  = imem_rsp_valid && !w_drop_zero;

    // Filled entries form a prefix, so an unfilled head is exactly the slot this response fills.
    assign w_bypass    = w_head_vld && !w_head_filled && w_rsp_take;
    assign w_adv       = !PCSrcE && !FlushD && !StallD;
    assign w_pop       = w_adv && w_head_vld && (w_head_filled || w_bypass);

    assign w_drop_redirect = DW'(w_unfilled) - DW'(w_rsp_match) + r_drop - DW'(w_rsp_drop);

    assign imem_req_valid = w_req_vld;
    assign imem_addr      = r_pcf;
    assign InstrD         = r_instr_d;
    assign PCD            = r_pc_d;
    assign PCPlus4D       = r_pc4_d;
    assign ValidD         = r_valid_d;

    fetch_prefetch_buf #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk            (clk),
        .rst            (rst),
        .i_clear        (PCSrcE),
        .i_reserve      (w_req_fire),
        .i_reserve_pc   (r_pcf),
        .i_fill         (w_rsp_take),
        .i_fill_instr   (imem_rsp_instr),
        .i_pop          (w_pop),
        .o_full         (w_full),
        .o_head_vld     (w_head_vld),
        .o_head_filled  (w_head_filled),
        .o_head_pc      (w_head_pc),
        .o_head_instr   (w_head_instr),
        .o_unfilled_cnt (w_unfilled),
        .o_has_unfilled (w_has_unfilled)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcf <= RESET_PC;
        end else if (PCSrcE) begin
            r_pcf <= PCTargetE;
        end else if (w_req_fire) begin
            r_pcf <= r_pcf + XLEN'(4);
        end
    end

    // Responses still owed for abandoned requests are counted here and swallowed on arrival.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop <= '0;
        end else if (PCSrcE) begin
            r_drop <= w_drop_redirect;
        end else if (w_rsp_drop) begin
            r_drop <= r_drop - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || PCSrcE || FlushD) begin
            r_instr_d <= NOP_INSTR;
            r_pc_d    <= '0;
            r_pc4_d   <= '0;
            r_valid_d <= 1'b0;
        end else if (!StallD) begin
            if (w_head_filled) begin
                r_instr_d <= w_head_instr;
                r_pc_d    <= w_head_pc;
                r_pc4_d   <= w_head_pc + XLEN'(4);
                r_valid_d <= 1'b1;
            end else if (w_bypass) begin
                r_instr_d <= imem_rsp_instr;
                r_pc_d    <= w_head_pc;
                r_pc4_d   <= w_head_pc + XLEN'(4);
                r_valid_d <= 1'b1;
            end else begin
                r_instr_d <= NOP_INSTR;
                r_pc_d    <= '0;
                r_pc4_d   <= '0;
                r_valid_d <= 1'b0;
            end
        end
    end

    a_rsp_has_owner: assert property (@(posedge clk) disable iff (rst)
        !(imem_rsp_valid && w_drop_zero && !w_has_unfilled));

endmodule

// File: tb/tb_fetch_stage_prefetch.sv
// Bench for fetch_stage_prefetch: queue-based fetch model plus a fixed-latency in-order memory model.
module tb_fetch_stage_prefetch;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        PCSrcE = 1'b0;
    logic [31:0] PCTargetE = '0;
    logic        StallD = 1'b0;
    logic        FlushD = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_instr = '0;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;

    fetch_stage_prefetch dut (
        .clk            (clk),
        .rst            (rst),
        .PCSrcE         (PCSrcE),
        .PCTargetE      (PCTargetE),
        .StallD         (StallD),
        .FlushD         (FlushD),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_instr (imem_rsp_instr),
        .InstrD         (InstrD),
        .PCD            (PCD),
        .PCPlus4D       (PCPlus4D),
        .ValidD         (ValidD)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        bit          filled;
    } ent_t;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } mreq_t;

    ent_t        mq[$];
    mreq_t       memq[$];
    logic [31:0] m_pcf = '0;
    int          m_drop = 0;
    logic [31:0] m_instr = 32'h13;
    logic [31:0] m_pc = '0;
    logic        m_valid = 1'b0;
    int          cyc = 0;
    int          lat = 1;
    int          n_vec = 0;
    int          n_fail = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %08h expected %08h", name, cyc, act, exp);
        end
    endtask

    task automatic bubble();
        m_instr = 32'h13;
        m_pc    = '0;
        m_valid = 1'b0;
    endtask

    // One clock: present memory response, check request side, advance the model, check IF/ID.
    task automatic step();
        logic        rv;
        logic [31:0] ri;
        logic        exp_rv;
        logic        fire;
        logic [31:0] pcf_old;
        logic        take;
        logic        pop;
        int          first_unf;
        int          nunf;
        int          nd;

        rv = (memq.size() > 0) && (memq[0].due == cyc);
        ri = rv ? mem_word(memq[0].addr) : $urandom;
        imem_rsp_valid = rv;
        imem_rsp_instr = ri;
        #1;
        exp_rv = !rst && (mq.size() < DEPTH) && !PCSrcE;
        chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
        if (exp_rv) chk("req_addr", imem_addr, m_pcf);
        fire    = exp_rv && imem_req_ready;
        pcf_old = m_pcf;
        pop     = 1'b0;

        if (rst) begin
            mq.delete();
            m_drop = 0;
            m_pcf  = 32'h0;
            bubble();
        end else begin
            first_unf = -1;
            nunf      = 0;
            foreach (mq[i]) begin
                if (!mq[i].filled) begin
                    if (first_unf < 0) first_unf = i;
                    nunf++;
                end
            end
            take = rv && (m_drop == 0) && (nunf > 0);

            if (PCSrcE || FlushD) begin
                bubble();
            end else if (!StallD) begin
                if (mq.size() > 0 && mq[0].filled) begin
                    m_instr = mq[0].instr; m_pc = mq[0].pc; m_valid = 1'b1; pop = 1'b1;
                end else if (mq.size() > 0 && take && first_unf == 0) begin
                    m_instr = ri; m_pc = mq[0].pc; m_valid = 1'b1; pop = 1'b1;
                end else begin
                    bubble();
                end
            end

            if (PCSrcE) begin
                nd = nunf - (take ? 1 : 0) + m_drop - ((rv && m_drop > 0) ? 1 : 0);
                m_drop = nd;
                mq.delete();
                m_pcf = PCTargetE;
            end else begin
                if (take) begin
                    mq[first_unf].instr  = ri;
                    mq[first_unf].filled = 1'b1;
                end else if (rv && m_drop > 0) begin
                    m_drop--;
                end
                if (pop) void'(mq.pop_front());
                if (fire) begin
                    mq.push_back('{pc: m_pcf, instr: 32'h0, filled: 1'b0});
                    m_pcf = m_pcf + 32'd4;
                end
            end
        end

        @(posedge clk);
        if (rv) void'(memq.pop_front());
        if (fire) memq.push_back('{due: cyc + lat, addr: pcf_old});
        if (rst) memq.delete();
        cyc++;
        @(negedge clk);
        chk("InstrD", InstrD, m_instr);
        chk("PCD", PCD, m_pc);
        chk("PCPlus4D", PCPlus4D, (m_valid ? m_pc + 32'd4 : 32'h0));
        chk("ValidD", {31'b0, ValidD}, {31'b0, m_valid});
    endtask

    task automatic idle_ctrl();
        rst = 1'b0; PCSrcE = 1'b0; StallD = 1'b0; FlushD = 1'b0;
    endtask

    task automatic drain();
        int guard;
        idle_ctrl();
        imem_req_ready = 1'b0;
        guard = 0;
        while (memq.size() > 0 && guard < 10) begin
            step();
            guard++;
        end
        chk("drain_done", memq.size(), 0);
    endtask

    initial begin
        bit seen;
        @(negedge clk);

        // Reset
        rst = 1'b1;
        repeat (3) step();
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
        chk("rst_InstrD", InstrD, 32'h0000_0013);
        chk("rst_PCD", PCD, 32'h0);
        chk("rst_ValidD", {31'b0, ValidD}, 32'h0);

        // Stream with 1-cycle memory
        idle_ctrl();
        imem_req_ready = 1'b1;
        step();
        chk("first_bubble", {31'b0, ValidD}, 32'h0);
        step();
        chk("first_valid", {31'b0, ValidD}, 32'h1);
        chk("first_PCD", PCD, 32'h0);
        chk("first_instr", InstrD, 32'hBEEF_0000);
        step();
        chk("second_PCD", PCD, 32'h4);
        chk("second_PC4", PCPlus4D, 32'h8);
        step();

        // Memory not ready for 5 cycles
        imem_req_ready = 1'b0;
        repeat (5) begin
            step();
            chk("ready0_addr", imem_addr, 32'h10);
        end
        chk("ready0_bubble", {31'b0, ValidD}, 32'h0);
        imem_req_ready = 1'b1;
        step();
        step();
        chk("resume_PCD", PCD, 32'h10);

        // Decode stall for 10 cycles: buffer fills to DEPTH
        StallD = 1'b1;
        repeat (10) step();
        chk("stall_full", {31'b0, imem_req_valid}, 32'h0);
        chk("stall_pcf", imem_addr, 32'h24);
        chk("stall_PCD", PCD, 32'h10);
        StallD = 1'b0;
        repeat (8) step();

        // 3-cycle memory, redirect with requests in flight
        drain();
        lat = 3;
        imem_req_ready = 1'b1;
        repeat (6) step();
        PCSrcE = 1'b1; PCTargetE = 32'h200;
        step();
        PCSrcE = 1'b0;
        chk("redir_bubble", {31'b0, ValidD}, 32'h0);
        chk("redir_pcf", imem_addr, 32'h200);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (ValidD) seen = 1'b1;
        end
        chk("redir_seen", {31'b0, seen}, 32'h1);
        chk("redir_PCD", PCD, 32'h200);
        chk("redir_instr", InstrD, 32'hBCEF_0200);

        // Redirect together with stall
        repeat (3) step();
        StallD = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h300;
        step();
        chk("redir_stall_bubble", {31'b0, ValidD}, 32'h0);
        chk("redir_stall_pcf", imem_addr, 32'h300);
        StallD = 1'b0; PCSrcE = 1'b0;
        repeat (8) step();

        // FlushD alone
        FlushD = 1'b1;
        step();
        chk("flush_bubble", {31'b0, ValidD}, 32'h0);
        FlushD = 1'b0;
        repeat (8) step();

        // Reset mid-stream with responses pending
        rst = 1'b1;
        step();
        chk("mid_rst_InstrD", InstrD, 32'h0000_0013);
        chk("mid_rst_ValidD", {31'b0, ValidD}, 32'h0);
        rst = 1'b0;
        step();
        chk("mid_rst_restart_addr", imem_addr, 32'h4);
        repeat (6) step();

        // Randomised segments at each memory latency
        for (int seg = 0; seg < 3; seg++) begin
            drain();
            lat = seg + 1;
            for (int k = 0; k < 400; k++) begin
                rst            = ($urandom_range(0, 199) == 0);
                PCSrcE         = ($urandom_range(0, 19) == 0);
                PCTargetE      = $urandom & 32'h0000_FFFF;
                StallD         = ($urandom_range(0, 4) == 0);
                FlushD         = ($urandom_range(0, 19) == 0);
                imem_req_ready = ($urandom_range(0, 3) != 0);
                step();
            end
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
